ysyx_22041405_exu_ctrl: RTL
===========================

# ysyx_22041405_exu_ctrl

Execute-stage controller between IDU and WBU. Accepts one decoded instruction per valid/ready handshake, drives the shared combinational ALU for single-cycle ops, and sequences an iterative 32-step multiply/divide unit for RV32M ops. It returns a registered result to WBU through a second valid/ready handshake. One instruction is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, datapath width; the MDU step count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the in-flight op
- in_valid  in  1  IDU offers an instruction
- in_ready  out  1  controller can accept
- in_rs1, in_rs2, in_imm  in  WIDTH  operands
- in_src2_sel  in  1  1 = use imm as src2
- in_alu_opcode  in  8  ALU opcode, passed through
- in_add_or_sub, in_U_or_S  in  1  ALU modifiers
- in_md_en  in  1  1 = RV32M op
- in_md_op  in  3  RV32M funct3 (0 MUL … 7 REMU)
- alu_src1, alu_src2  out  WIDTH  to ALU
- alu_opcode  out  8  to ALU
- alu_add_or_sub, alu_U_or_S  out  1  to ALU
- alu_result  in  WIDTH  from ALU
- out_valid  out  1  result available
- out_ready  in  1  WBU accepts
- out_result  out  WIDTH  registered result
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE
  - MD_RUN
  - DONE
- Accept when `in_valid && in_ready`. The accept cycle is the **fire** cycle.
- `in_ready = (IDLE) || (DONE && out_ready)`. This allows back-to-back issue.
- ALU op (`in_md_en=0`):
  - ALU inputs come combinationally from the in_* ports during the fire cycle.
  - alu_src2 = in_src2_sel ? in_imm : in_rs2.
  - alu_result is captured into out_result; next state is DONE.
  - Outside a fire cycle, ALU control outputs are driven with the latched op, or 0 after reset.
- MD op:
  - Latch operands; next state is MD_RUN with step counter 0.
  - Signed ops operate on absolute values. The sign of the result is fixed up at completion.
- MUL:
  - Unsigned shift-add, one bit per cycle, 64-bit product.
  - MUL returns the low word. MULH, MULHSU and MULHU return the high word. MULHSU treats rs2 as unsigned.
- DIV/REM:
  - Restoring division, one quotient bit per cycle.
  - Remainder takes the dividend's sign. The quotient is negated when the operand signs differ.
- DIV/REM special cases complete without entering MD_RUN (DONE next cycle):
  - divide by zero: DIV/DIVU → all-ones; REM/REMU → dividend
  - signed overflow (0x80000000 / −1): DIV → 0x80000000; REM → 0
- MD_RUN → DONE after step WIDTH−1. out_result is loaded in the same cycle.
- DONE:
  - out_valid=1; out_result is held stable until out_ready.
  - out_ready && !in_valid → IDLE.
  - out_ready && in_valid → fire the new op; an ALU op goes to DONE, an MD op goes to MD_RUN.
- flush in any state: → IDLE next edge, out_valid=0, the result is dropped. flush has priority over fire and completion.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, busy 0, all alu_* outputs 0, step counter 0. in_ready is 1 out of reset.
- ALU op: fire at cycle N → out_valid at N+1.
- MD op: fire at N → out_valid at N+WIDTH+1 (N+33).
- MD special case: out_valid at N+1.
- out_valid never drops without out_ready or flush. in_valid asserted during MD_RUN is ignored (in_ready=0).
- Reset asserted mid-MD_RUN returns to IDLE immediately. No partial result is ever presented.

## Structure
- Shared header `ysyx_22041405_defines.vh`: state encodings, RV32M funct3 constants (MUL=0 … REMU=7), WIDTH default.
- Sub-module `ysyx_22041405_mdu_iter`:
  - start / op / operand inputs, done pulse and result output
  - owns the step counter, partial product/remainder and sign fixup
- This controller holds the FSM, handshake logic, ALU muxing and the output register.

## Test plan
- ADD: rs1=5, rs2=7, src2_sel=0 → out_result=12, out_valid exactly 1 cycle after fire.
- ADDI back-to-back with out_ready held 1: three consecutive ops, imm=−1, 0, 1 on rs1=10 → results 9, 10, 11 on consecutive cycles.
- MULH rs1=0xFFFFFFFF (−1), rs2=2 → 0xFFFFFFFF at fire+33. MULHU same operands → 0x00000001.
- DIV/REM cases, all at fire+1 except the last:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000
  - REMU 7/0 → 7
  - DIVU 7/0 → 0xFFFFFFFF
  - REM −7/2 → −1 at fire+33
- Backpressure: out_ready=0 for 5 cycles after MULU completes → out_result stable, in_ready=0; out_ready=1 → handshake, return to IDLE.
- Flush at MD_RUN step 10, then reset pulse at step 5 of a new DIV → IDLE, out_valid never asserted; a following ADD completes normally.

Source files
------------

// File: rtl/ysyx_22041405_exu_ctrl_pkg.sv
// Shared types and RV32M constants for the execute-stage controller.
// Imported by the controller and the iterative multiply/divide unit.
package ysyx_22041405_exu_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MD_RUN = 2'd1,
    DONE   = 2'd2
  } exu_state_t;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_sgn1(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_sgn2(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) ||
           (op == MD_REM);
  endfunction

endpackage

// File: rtl/ysyx_22041405_mdu_iter.sv
// Iterative RV32M unit: shift-add multiply and restoring divide,
// one bit per cycle on magnitudes, sign fixed up on the last step.
module ysyx_22041405_mdu_iter
  import ysyx_22041405_exu_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic               running;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               neg_r;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign neg1 = md_sgn1(op) && src1[WIDTH-1];
  assign neg2 = md_sgn2(op) && src2[WIDTH-1];
  assign abs1 = neg1 ? -src1 : src1;
  assign abs2 = neg2 ? -src2 : src2;

  // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvs};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, dvs};
    div_ge   = ~div_diff[WIDTH];
    if (md_is_div(op_q))
      acc_nxt = {div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0],
                 acc[WIDTH-2:0], div_ge};
    else if (acc[0])
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem  = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    unique case (op_q)
      MD_MUL:                       result = prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              result = quo;
      MD_REM, MD_REMU:              result = rem;
      default:                      result = '0;
    endcase
  end

  assign done = running && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      dvs     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (kill) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_q    <= op;
      neg_q   <= neg1 ^ neg2;
      neg_r   <= neg1;
      if (md_is_div(op)) begin
        acc <= {{WIDTH{1'b0}}, abs1};
        dvs <= abs2;
      end else begin
        acc <= {{WIDTH{1'b0}}, abs2};
        dvs <= abs1;
      end
    end else if (running) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041405_exu_ctrl.sv
// Execute-stage controller: IDU/WBU handshakes, ALU operand muxing,
// RV32M sequencing and the registered result towards writeback.
module ysyx_22041405_exu_ctrl
  import ysyx_22041405_exu_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_src2_sel,
  input  logic [7:0]       in_alu_opcode,
  input  logic             in_add_or_sub,
  input  logic             in_U_or_S,
  input  logic             in_md_en,
  input  logic [2:0]       in_md_op,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [7:0]       alu_opcode,
  output logic             alu_add_or_sub,
  output logic             alu_U_or_S,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  exu_state_t       state;
  logic             fire;
  logic [WIDTH-1:0] src2_mux;
  logic [WIDTH-1:0] lat_src1, lat_src2;
  logic [7:0]       lat_opcode;
  logic             lat_aos, lat_uos;
  logic             div_zero, div_ovf, md_special, md_start, md_done;
  logic [WIDTH-1:0] special_val, md_result;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign fire     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign src2_mux = in_src2_sel ? in_imm : in_rs2;

  always_comb begin
    alu_src1       = lat_src1;
    alu_src2       = lat_src2;
    alu_opcode     = lat_opcode;
    alu_add_or_sub = lat_aos;
    alu_U_or_S     = lat_uos;
    if (fire) begin
      alu_src1       = in_rs1;
      alu_src2       = src2_mux;
      alu_opcode     = in_alu_opcode;
      alu_add_or_sub = in_add_or_sub;
      alu_U_or_S     = in_U_or_S;
    end
  end

  // Divide corner cases resolve at issue and skip the iterative unit
  assign div_zero = (in_rs2 == '0);
  assign div_ovf  = md_sgn2(in_md_op) &&
                    (in_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_rs2);
  assign md_special = in_md_en && md_is_div(in_md_op) &&
                      (div_zero || div_ovf);
  assign special_val = div_zero ?
                       (in_md_op[1] ? in_rs1 : '1) :
                       (in_md_op[1] ? '0 : in_rs1);
  assign md_start = fire && in_md_en && !md_special && !flush;

  ysyx_22041405_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .kill   (flush),
    .op     (in_md_op),
    .src1   (in_rs1),
    .src2   (in_rs2),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      lat_src1   <= '0;
      lat_src2   <= '0;
      lat_opcode <= '0;
      lat_aos    <= 1'b0;
      lat_uos    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (fire) begin
      lat_src1   <= in_rs1;
      lat_src2   <= src2_mux;
      lat_opcode <= in_alu_opcode;
      lat_aos    <= in_add_or_sub;
      lat_uos    <= in_U_or_S;
      unique case (1'b1)
        !in_md_en: begin
          out_result <= alu_result;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        md_special: begin
          out_result <= special_val;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= MD_RUN;
        end
      endcase
    end else begin
      unique case (1'b1)
        state == MD_RUN && md_done: begin
          out_result <= md_result;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        state == DONE && out_ready: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
